// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and bit timing.
package uart_rx_pkg;

  // Ticks of the oversampling clock per serial bit.
  localparam int unsigned OVERSAMPLE = 8;

  // Last tick of a bit; every state transition happens on this tick.
  localparam logic [2:0] EDGE_LAST = 3'd7;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the receive controller and its datapath (sampler, deserializer, checkers).
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                 rx_in;
  logic                 par_en;
  logic                 strt_glitch;
  logic                 par_err;
  logic                 stp_err;
  logic [2:0]           edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 dat_samp_en;
  logic                 deser_en;
  logic                 strt_chk_en;
  logic                 par_chk_en;
  logic                 stp_chk_en;
  logic                 data_valid;
  logic                 parity_error;
  logic                 framing_error;

  // Controller side.
  modport master (
    input  rx_in, par_en, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
    output data_valid, parity_error, framing_error
  );

  // Datapath / line side.
  modport slave (
    output rx_in, par_en, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
    input  data_valid, parity_error, framing_error
  );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Tick-within-bit counter and data bit index shared by the whole receive path.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  localparam int unsigned BIT_CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_en,
  input  logic                 bit_inc,
  input  logic                 bit_clr,
  output logic [2:0]           edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 edge_last
);

  // Edge counter free-runs (wrapping 7->0) while a frame is active; bit index steps on request.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      edge_cnt <= cnt_en ? edge_cnt + 3'd1 : 3'd0;
      if (bit_clr) begin
        bit_cnt <= '0;
      end else if (bit_inc) begin
        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
    end
  end

  assign edge_last = (edge_cnt == EDGE_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: walks START/DATA/PARITY/STOP, drives datapath enables, reports status.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.master bus
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_e               state_q;
  logic                 par_en_q;
  logic                 par_err_q;
  logic                 data_valid_q;
  logic                 parity_error_q;
  logic                 framing_error_q;
  logic [2:0]           edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 edge_last;
  logic                 bit_last;
  logic                 cnt_en;
  logic                 bit_inc;
  logic                 bit_clr;

  assign bit_last = (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1));
  assign cnt_en   = (state_q != StIdle);
  assign bit_inc  = (state_q == StData) && edge_last && !bit_last;
  // Holding the index at zero in IDLE guarantees every frame starts at bit 0, even after a glitch.
  assign bit_clr  = !cnt_en || ((state_q == StData) && edge_last && bit_last);

  uart_rx_edge_bit_cnt #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .cnt_en    (cnt_en),
    .bit_inc   (bit_inc),
    .bit_clr   (bit_clr),
    .edge_cnt  (edge_cnt),
    .bit_cnt   (bit_cnt),
    .edge_last (edge_last)
  );

  // State register, latched frame options and registered end-of-frame status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      par_en_q        <= 1'b0;
      par_err_q       <= 1'b0;
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      data_valid_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!bus.rx_in) begin
            state_q  <= StStart;
            par_en_q <= bus.par_en;
          end
        end
        StStart: begin
          if (edge_last) begin
            state_q <= bus.strt_glitch ? StIdle : StData;
          end
        end
        StData: begin
          if (edge_last && bit_last) begin
            state_q <= par_en_q ? StParity : StStop;
          end
        end
        StParity: begin
          if (edge_last) begin
            par_err_q <= bus.par_err;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (edge_last) begin
            // Framing error outranks parity error; exactly one pulse per completed frame.
            framing_error_q <= bus.stp_err;
            parity_error_q  <= !bus.stp_err && par_err_q;
            data_valid_q    <= !bus.stp_err && !par_err_q;
            par_err_q       <= 1'b0;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Enables are plain decodes of the registered state.
  assign bus.dat_samp_en   = (state_q != StIdle);
  assign bus.strt_chk_en   = (state_q == StStart);
  assign bus.deser_en      = (state_q == StData);
  assign bus.par_chk_en    = (state_q == StParity);
  assign bus.stp_chk_en    = (state_q == StStop);
  assign bus.edge_cnt      = edge_cnt;
  assign bus.bit_cnt       = bit_cnt;
  assign bus.data_valid    = data_valid_q;
  assign bus.parity_error  = parity_error_q;
  assign bus.framing_error = framing_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame timing, enables, status priority, reset and back-to-back.
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-frame observations gathered by run_frame.
  int n_dv, n_pe, n_fe, dv_t0, dv_t1, pe_t, fe_t;
  int deser_n, par_n, strt_n, stp_n, win_bad, start2_t;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serial line level at tick t of a frame (start, LSB-first data, optional parity, stop/idle).
  function automatic logic line_bit(input int t, input logic [7:0] d, input logic pe);
    int b;
    b = t / 8;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return ^d;
    return 1'b1;
  endfunction

  function automatic int all_outs();
    return int'({bus.dat_samp_en, bus.deser_en, bus.strt_chk_en, bus.par_chk_en,
                 bus.stp_chk_en, bus.data_valid, bus.parity_error, bus.framing_error});
  endfunction

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    check("rst_outs", all_outs(), 0);
    check("rst_edge", int'(bus.edge_cnt), 0);
    check("rst_bit", int'(bus.bit_cnt), 0);
    rst = 1'b0;
  endtask

  // Start a frame and stop after n ticks, leaving the DUT mid-frame.
  task automatic begin_frame(input logic pe, input logic perr, input int n);
    bus.par_en  = pe;
    bus.par_err = perr;
    bus.rx_in   = 1'b0;
    step();
    bus.rx_in = 1'b1;
    repeat (n) step();
  endtask

  // Start a frame (START entered at t=0) and observe ncyc ticks.
  task automatic run_frame(input logic [7:0] data, input logic pe, input logic perr,
                           input logic serr, input logic glitch, input logic tog,
                           input logic b2b, input int ncyc);
    int   flen, win, t0, exp_edge, exp_bit;
    logic exp_act, prev_strt;
    flen = glitch ? 8 : (pe ? 88 : 80);
    win  = b2b ? 81 : flen + 1;
    n_dv = 0; n_pe = 0; n_fe = 0; dv_t0 = -1; dv_t1 = -1; pe_t = -1; fe_t = -1;
    deser_n = 0; par_n = 0; strt_n = 0; stp_n = 0; win_bad = 0; start2_t = -1;
    t0 = 0;
    prev_strt = 1'b0;
    bus.par_en      = pe;
    bus.par_err     = perr;
    bus.stp_err     = serr;
    bus.strt_glitch = glitch;
    bus.rx_in       = 1'b0;
    step();
    for (int t = 0; t < ncyc; t++) begin
      if (bus.data_valid) begin
        n_dv++;
        if (dv_t0 < 0) dv_t0 = t;
        else if (dv_t1 < 0) dv_t1 = t;
      end
      if (bus.parity_error) begin n_pe++; if (pe_t < 0) pe_t = t; end
      if (bus.framing_error) begin n_fe++; if (fe_t < 0) fe_t = t; end
      deser_n += int'(bus.deser_en);
      par_n   += int'(bus.par_chk_en);
      strt_n  += int'(bus.strt_chk_en);
      stp_n   += int'(bus.stp_chk_en);
      if (bus.strt_chk_en && !prev_strt && t > 0 && start2_t < 0) start2_t = t;
      prev_strt = bus.strt_chk_en;
      if (t < win) begin
        exp_act  = (t < flen);
        exp_edge = exp_act ? t % 8 : 0;
        exp_bit  = (!glitch && t >= 8 && t < 72) ? (t - 8) / 8 : 0;
        if (bus.dat_samp_en !== exp_act || int'(bus.edge_cnt) != exp_edge ||
            int'(bus.bit_cnt) != exp_bit) win_bad++;
      end
      if (tog) bus.par_en = ~bus.par_en;
      if (b2b && bus.data_valid && n_dv == 1) begin
        t0 = t + 1;
        bus.par_en = pe;
      end
      bus.rx_in = glitch ? 1'b1 : line_bit(t + 1 - t0, data, pe);
      step();
    end
    bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.par_err = 1'b0;
    bus.stp_err = 1'b0; bus.strt_glitch = 1'b0;
  endtask

  initial begin
    int quiet_bad;
    rst = 1'b1;
    bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.strt_glitch = 1'b0;
    bus.par_err = 1'b0; bus.stp_err = 1'b0;

    // Power-on reset.
    apply_reset(3);
    step();

    // Reset mid-DATA at bit 4 aborts the frame silently.
    begin_frame(1'b0, 1'b0, 40);
    check("mid_bit_cnt", int'(bus.bit_cnt), 4);
    check("mid_deser", int'(bus.deser_en), 1);
    apply_reset(3);
    quiet_bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (all_outs() != 0) quiet_bad++;
    end
    check("post_rst_quiet", quiet_bad, 0);

    // 0xA5, no parity, clean.
    run_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 95);
    check("a5_dv_time", dv_t0, 80);
    check("a5_dv_count", n_dv, 1);
    check("a5_pe", n_pe, 0);
    check("a5_fe", n_fe, 0);
    check("a5_deser", deser_n, 64);
    check("a5_strt", strt_n, 8);
    check("a5_par", par_n, 0);
    check("a5_stp", stp_n, 8);
    check("a5_window", win_bad, 0);

    // 0x3C with parity, parity error.
    run_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 100);
    check("perr_time", pe_t, 88);
    check("perr_count", n_pe, 1);
    check("perr_dv", n_dv, 0);
    check("perr_fe", n_fe, 0);
    check("perr_parchk", par_n, 8);
    check("perr_window", win_bad, 0);

    // Stop error only.
    run_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    check("ferr_time", fe_t, 88);
    check("ferr_count", n_fe, 1);
    check("ferr_pe", n_pe, 0);
    check("ferr_dv", n_dv, 0);

    // Both errors: framing wins.
    run_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    check("both_fe_time", fe_t, 88);
    check("both_pe", n_pe, 0);
    check("both_dv", n_dv, 0);

    // Start glitch returns to IDLE after the start bit.
    run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 40);
    check("glitch_pulses", n_dv + n_pe + n_fe, 0);
    check("glitch_deser", deser_n, 0);
    check("glitch_strt", strt_n, 8);
    check("glitch_window", win_bad, 0);

    // Back-to-back frames with par_en toggling mid-frame.
    run_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 175);
    check("b2b_dv0", dv_t0, 80);
    check("b2b_start2", start2_t, 81);
    check("b2b_dv1", dv_t1, 161);
    check("b2b_dv_count", n_dv, 2);
    check("b2b_parchk", par_n, 0);
    check("b2b_deser", deser_n, 128);
    check("b2b_errs", n_pe + n_fe, 0);
    check("b2b_window", win_bad, 0);

    // Reset during STOP of a parity-error frame must clear the latched parity error.
    begin_frame(1'b1, 1'b1, 84);
    check("stop_reached", int'(bus.stp_chk_en), 1);
    apply_reset(3);
    step();
    run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 90);
    check("clr_dv_time", dv_t0, 80);
    check("clr_pe", n_pe, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
